// File: rtl/branch_cond_unit.sv
// Purpose: resolve a signed branch condition, pick next-PC, queue {taken, pc} toward fetch.
// Latency: entry pushed at edge N is presented at out_* after edge N (combinational read of head).
// Backpressure: in_ready = !full only; a full queue refuses input even while it pops.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   flush               drops all queued entries and the same-cycle input, suppresses pop
//   in_valid/in_ready   request handshake carrying in_a, in_cond, in_pc_next, in_target
//   out_valid/out_ready head-entry handshake carrying out_taken, out_pc
//   eval_count          saturating count of accepted evaluations
//   taken_count         saturating count of accepted taken evaluations
module branch_cond_unit #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [2:0]           in_cond,
    input  logic [WIDTH-1:0]     in_pc_next,
    input  logic [WIDTH-1:0]     in_target,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_taken,
    output logic [WIDTH-1:0]     out_pc,
    output logic [CNT_WIDTH-1:0] eval_count,
    output logic [CNT_WIDTH-1:0] taken_count
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [2:0] COND_NEVER  = 3'd0;
    localparam logic [2:0] COND_LT     = 3'd1;
    localparam logic [2:0] COND_GT     = 3'd2;
    localparam logic [2:0] COND_EQ     = 3'd3;
    localparam logic [2:0] COND_NE     = 3'd4;
    localparam logic [2:0] COND_LE     = 3'd5;
    localparam logic [2:0] COND_GE     = 3'd6;
    localparam logic [2:0] COND_ALWAYS = 3'd7;

    localparam logic [AW:0]          PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]          wr_ptr_q, wr_ptr_d;
    logic [AW:0]          rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0] eval_cnt_q, eval_cnt_d;
    logic [CNT_WIDTH-1:0] taken_cnt_q, taken_cnt_d;

    // Storage is never reset; out_* are don't-care while empty.
    logic [WIDTH:0] mem_q [DEPTH];
    logic [WIDTH:0] mem_d [DEPTH];

    logic             a_neg, a_zero, taken;
    logic [WIDTH-1:0] pc_sel;
    logic             full, empty, push, pop;

    always_comb begin
        a_neg  = in_a[WIDTH-1];
        a_zero = (in_a == '0);
        taken  = 1'b0;
        case (in_cond)
            COND_NEVER:  taken = 1'b0;
            COND_LT:     taken = a_neg;
            COND_GT:     taken = !a_neg && !a_zero;
            COND_EQ:     taken = a_zero;
            COND_NE:     taken = !a_zero;
            COND_LE:     taken = a_neg || a_zero;
            COND_GE:     taken = !a_neg;
            COND_ALWAYS: taken = 1'b1;
            default:     taken = 1'b0;
        endcase
        pc_sel = taken ? in_target : in_pc_next;
    end

    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    assign in_ready  = !full;
    assign out_valid = !empty;

    // A flush cycle still completes the input handshake, but nothing is stored or counted.
    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        eval_cnt_d  = eval_cnt_q;
        taken_cnt_d = taken_cnt_q;
        mem_d       = mem_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
                mem_d[wr_ptr_q[AW-1:0]] = {taken, pc_sel};
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
        end

        if (push && (eval_cnt_q != CNT_MAX)) begin
            eval_cnt_d = eval_cnt_q + CNT_ONE;
        end
        if (push && taken && (taken_cnt_q != CNT_MAX)) begin
            taken_cnt_d = taken_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            eval_cnt_q  <= '0;
            taken_cnt_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            eval_cnt_q  <= eval_cnt_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    // A write during reset is harmless: reset empties the queue, so the entry is never read.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign out_taken   = mem_q[rd_ptr_q[AW-1:0]][WIDTH];
    assign out_pc      = mem_q[rd_ptr_q[AW-1:0]][WIDTH-1:0];
    assign eval_count  = eval_cnt_q;
    assign taken_count = taken_cnt_q;

endmodule

// File: tb/tb_branch_cond_unit.sv
// Purpose: randomized and directed stimulus for branch_cond_unit against a queue-based model.
// Latency: outputs sampled mid-cycle (after negedge), model advanced at each posedge.
// Backpressure: model derives accept/pop from its own occupancy, not from the DUT.
module tb_branch_cond_unit;

    localparam int W     = 32;
    localparam int DEPTH = 4;
    localparam int CW    = 3;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n, flush, in_valid, in_ready, out_valid, out_ready, out_taken;
    logic [W-1:0]  in_a, in_pc_next, in_target, out_pc;
    logic [2:0]    in_cond;
    logic [CW-1:0] eval_count, taken_count;

    branch_cond_unit #(.WIDTH(W), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_cond    (in_cond),
        .in_pc_next (in_pc_next),
        .in_target  (in_target),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_taken  (out_taken),
        .out_pc     (out_pc),
        .eval_count (eval_count),
        .taken_count(taken_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         tk;
        logic [W-1:0] pc;
    } ent_t;

    ent_t q[$];
    int   m_eval, m_taken;
    bit   known;
    int   n_checks, n_fail;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference: signed comparison of a against zero, straight from the condition table.
    function automatic bit ref_taken(input logic [W-1:0] a, input int c);
        int signed s;
        s = a;
        case (c)
            0: return 1'b0;
            1: return s < 0;
            2: return s > 0;
            3: return s == 0;
            4: return s != 0;
            5: return s <= 0;
            6: return s >= 0;
            default: return 1'b1;
        endcase
    endfunction

    // One clock cycle: drive, check mid-cycle, advance model at posedge.
    task automatic cyc(input bit vld, input logic [W-1:0] a, input int c,
                       input logic [W-1:0] pcn, input logic [W-1:0] tgt,
                       input bit rdy, input bit fl, input bit rn);
        bit   m_push, m_pop, tk;
        ent_t e;
        in_valid   = vld;
        in_a       = a;
        in_cond    = c[2:0];
        in_pc_next = pcn;
        in_target  = tgt;
        out_ready  = rdy;
        flush      = fl;
        rst_n      = rn;
        #1;
        if (known) begin
            chk("in_ready", in_ready, q.size() < DEPTH);
            chk("out_valid", out_valid, q.size() > 0);
            if (q.size() > 0) begin
                chk("out_taken", out_taken, q[0].tk);
                chk("out_pc", out_pc, q[0].pc);
            end
            chk("eval_count", eval_count, m_eval);
            chk("taken_count", taken_count, m_taken);
        end
        tk     = ref_taken(a, c);
        m_push = vld && (q.size() < DEPTH) && !fl;
        m_pop  = rdy && (q.size() > 0) && !fl;
        @(posedge clk);
        if (!rn) begin
            q.delete();
            m_eval  = 0;
            m_taken = 0;
            known   = 1'b1;
        end else if (known) begin
            if (fl) q.delete();
            if (m_pop) void'(q.pop_front());
            if (m_push) begin
                e.tk = tk;
                e.pc = tk ? tgt : pcn;
                q.push_back(e);
                if (m_eval < CMAX) m_eval++;
                if (tk && m_taken < CMAX) m_taken++;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input bit rdy);
        cyc(1'b0, '0, 0, '0, '0, rdy, 1'b0, 1'b1);
    endtask

    task automatic rnd_push(input bit rdy);
        cyc(1'b1, $urandom, int'($urandom_range(0, 7)), $urandom, $urandom, rdy, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        cyc(1'b0, '0, 0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    logic [W-1:0] avals [3];
    logic [W-1:0] ha, hp, ht;
    int           hc;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        known    = 1'b0;
        m_eval   = 0;
        m_taken  = 0;
        @(negedge clk);
        do_reset();
        do_reset();

        // Conditions: sign boundary, zero, one across all codes.
        avals[0] = 32'h8000_0000;
        avals[1] = 32'h0000_0000;
        avals[2] = 32'h0000_0001;
        for (int i = 0; i < 3; i++)
            for (int c = 0; c < 8; c++)
                cyc(1'b1, avals[i], c, 32'h104, 32'h200, 1'b1, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Fill and backpressure: 4 accepted, 5th held until a pop frees space.
        do_reset();
        for (int i = 0; i < 4; i++) rnd_push(1'b0);
        ha = $urandom; hc = 3; hp = $urandom; ht = $urandom;
        cyc(1'b1, ha, hc, hp, ht, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, ha, hc, hp, ht, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, ha, hc, hp, ht, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, ha, hc, hp, ht, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) idle(1'b1);

        // Simultaneous push/pop at occupancy 2, wrapping the pointers.
        do_reset();
        rnd_push(1'b0);
        rnd_push(1'b0);
        for (int i = 0; i < 10; i++) rnd_push(1'b1);

        // Flush with 3 held, concurrent input and pop; next push must come out first.
        rnd_push(1'b0);
        cyc(1'b1, 32'h0, 7, 32'h11, 32'h22, 1'b1, 1'b1, 1'b1);
        cyc(1'b1, 32'h5, 2, 32'h33, 32'h44, 1'b0, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Counter saturation: 10 always-taken pushes, then hold.
        do_reset();
        for (int i = 0; i < 10; i++)
            cyc(1'b1, $urandom, 7, $urandom, $urandom, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Reset with full queue and nonzero counters.
        do_reset();
        for (int i = 0; i < 5; i++) rnd_push(1'b0);
        cyc(1'b1, 32'h0, 7, 32'h1, 32'h2, 1'b1, 1'b1, 1'b0);
        idle(1'b0);

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), $urandom, int'($urandom_range(0, 7)),
                $urandom, $urandom, 1'($urandom_range(0, 2) != 0),
                1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 79) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
